dram_dump_reader: RTL and testbench

Data-memory responder for the RISC-V CPU load/store port. It includes a hardware dump engine that reads back the whole array.
- CPU side: combinational read, synchronous write.
- Dump side: a rising edge on DUMP starts an FSM that walks every word in address order and streams (address, data) pairs over a valid/ready port to a synthesizable checker or a host link.
- It sits beside the CPU in place of the behavioural data RAM, so the final memory image can be observed in silicon and in simulation.

---
 rtl/dram_dump_reader.sv | 146 ++++++++++++++
 tb/tb_dram_dump_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_dump_reader.sv
// dram_dump_reader: CPU data RAM with a streaming (addr, data) dump engine.
// Optional: define DUMP_SKIP_ZERO_EN to drop zero words from the dump.
module dram_dump_reader #(
  parameter int NB            = 32,
  parameter int MEM_ADDR_SIZE = 12
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     RD,
  input  logic                     WR,
  input  logic [MEM_ADDR_SIZE-1:0] ADDRESS,
  input  logic [NB-1:0]            DATAIN,
  output logic [NB-1:0]            DATAOUT,
  input  logic                     DUMP,
  output logic                     DUMP_VALID,
  input  logic                     DUMP_READY,
  output logic [MEM_ADDR_SIZE-1:0] DUMP_ADDR,
  output logic [NB-1:0]            DUMP_DATA,
  output logic                     DUMP_LAST,
  output logic                     BUSY,
  output logic                     DUMP_DONE
);

  localparam int AW = MEM_ADDR_SIZE - 2;
  localparam int NW = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  logic [NB-1:0] mem_q [NW];
  logic [AW-1:0] widx;
  logic          unused_addr_lo;

  assign widx           = ADDRESS[MEM_ADDR_SIZE-1:2];
  assign unused_addr_lo = ^ADDRESS[1:0];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (WR) begin
      mem_q[widx] <= DATAIN;
    end
  end

  assign DATAOUT = RD ? mem_q[widx] : '0;

  logic [1:0]               state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic                     dump_prev_q, dump_prev_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [NB-1:0]            data_q, data_d;
  logic [NB-1:0]            cur_word;
  logic                     skip;

  assign cur_word = mem_q[cnt_q];

  // The final index is never skipped so the consumer always sees LAST.
`ifdef DUMP_SKIP_ZERO_EN
  assign skip = (cur_word == '0) && (cnt_q != CNT_MAX);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dump_prev_d = DUMP;
    valid_d     = valid_q;
    last_d      = last_q;
    addr_d      = addr_q;
    data_d      = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (DUMP && !dump_prev_q) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (skip) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          data_d  = cur_word;
          addr_d  = {cnt_q, 2'b00};
          last_d  = (cnt_q == CNT_MAX);
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && DUMP_READY) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dump_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dump_prev_q <= dump_prev_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign DUMP_VALID = valid_q;
  assign DUMP_LAST  = last_q;
  assign DUMP_ADDR  = addr_q;
  assign DUMP_DATA  = data_q;
  assign BUSY       = (state_q == S_LOAD) || (state_q == S_SEND);
  assign DUMP_DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_dram_dump_reader.sv
// tb_dram_dump_reader: table vectors, random CPU traffic and dump streams
// checked against an array model of the memory image.
module tb_dram_dump_reader;

  logic        CLK, RST_n, RD, WR, DUMP, DUMP_READY;
  logic [11:0] ADDRESS, DUMP_ADDR;
  logic [31:0] DATAIN, DATAOUT, DUMP_DATA;
  logic        DUMP_VALID, DUMP_LAST, BUSY, DUMP_DONE;

  dram_dump_reader #(.NB(32), .MEM_ADDR_SIZE(12)) dut (
    .CLK(CLK), .RST_n(RST_n), .RD(RD), .WR(WR),
    .ADDRESS(ADDRESS), .DATAIN(DATAIN), .DATAOUT(DATAOUT),
    .DUMP(DUMP), .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY),
    .DUMP_ADDR(DUMP_ADDR), .DUMP_DATA(DUMP_DATA),
    .DUMP_LAST(DUMP_LAST), .BUSY(BUSY), .DUMP_DONE(DUMP_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] snap [1024];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt [8];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  function automatic bit skip_on();
`ifdef DUMP_SKIP_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Next word index the stream should carry, starting the search at k.
  function automatic int next_emit(int from);
    int k = from;
    while (skip_on() && k < 1023 && snap[k] == 0) k++;
    return k;
  endfunction

  function automatic int expected_count();
    int n = 1;
    for (int i = 0; i < 1023; i++)
      if (!skip_on() || snap[i] != 0) n++;
    return n;
  endfunction

  task automatic run_dump(input int stall_word, input int stall_n,
                          input bit rand_rdy, input bit collide,
                          input bit hold_dump);
    int idx, emitted, left;
    bit hv, fin, lc;
    logic [45:0] hval;
    for (int i = 0; i < 1024; i++) snap[i] = ref_mem[i];
    idx = 0; emitted = 0; left = stall_n;
    hv = 0; fin = 0; lc = 0; hval = '0;
    @(negedge CLK);
    WR = 0; RD = 0; DUMP = 1; DUMP_READY = 0;
    @(negedge CLK);
    chk("busy_start", BUSY, 1);
    for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
      WR = 0;
      if (!hold_dump) DUMP = 0;
      if (lc) begin
        WR = 1; ADDRESS = 12'h014; DATAIN = 32'h00C0FFEE;
        ref_mem[5] = DATAIN;
        lc = 0;
      end
      if (DUMP_DONE) fin = 1;
      if (hv)
        chk("hold_stable",
            {DUMP_VALID, DUMP_LAST, DUMP_ADDR, DUMP_DATA}, hval);
      hv = 0;
      if (DUMP_VALID) begin
        if (left > 0 && DUMP_ADDR == stall_word * 4) begin
          DUMP_READY = 0; left--;
        end else begin
          DUMP_READY = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (!DUMP_READY) begin
          hv = 1;
          hval = {1'b1, DUMP_LAST, DUMP_ADDR, DUMP_DATA};
        end else begin
          idx = next_emit(idx);
          chk("dump_addr", DUMP_ADDR, idx * 4);
          chk("dump_data", DUMP_DATA, snap[idx]);
          chk("dump_last", DUMP_LAST, idx == 1023);
          emitted++;
          if (collide && idx == 3) begin
            WR = 1; ADDRESS = 12'h008; DATAIN = 32'hAAAA0002;
            ref_mem[2] = DATAIN;
          end
          if (collide && idx == 4) begin
            WR = 1; ADDRESS = 12'h7D0; DATAIN = 32'hBBBB01F4;
            ref_mem[500] = DATAIN;
            snap[500] = DATAIN;
            lc = 1;
          end
          if (!hold_dump && idx == 10) DUMP = 1;
          idx++;
        end
      end
      if (!fin) @(negedge CLK);
    end
    WR = 0;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL dump_timeout act=no_done exp=done");
    end
    chk("emitted", emitted, expected_count());
    @(negedge CLK);
    chk("done_once", DUMP_DONE, 0);
    chk("busy_after", BUSY, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("no_retrigger", {BUSY, DUMP_VALID, DUMP_DONE}, 0);
    end
    DUMP = 0; DUMP_READY = 0;
  endtask

  initial begin
    bit hit;
    RST_n = 0; RD = 0; WR = 0; DUMP = 0; DUMP_READY = 0;
    ADDRESS = '0; DATAIN = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    vt[0] = '{1'b1, 1'b0, 12'h000, 32'h0, 32'h0, "rd_lo"};
    vt[1] = '{1'b1, 1'b0, 12'hFFC, 32'h0, 32'h0, "rd_hi"};
    vt[2] = '{1'b0, 1'b0, 12'hFFC, 32'h0, 32'h0, "rd_off"};
    vt[3] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0, "wr_only"};
    vt[4] = '{1'b1, 1'b0, 12'h012, 32'h0, 32'hDEADBEEF, "rd_lowbits"};
    vt[5] = '{1'b1, 1'b1, 12'h010, 32'h12345678, 32'hDEADBEEF,
              "rw_old"};
    vt[6] = '{1'b1, 1'b0, 12'h013, 32'h0, 32'h12345678, "rd_new"};
    vt[7] = '{1'b0, 1'b0, 12'h010, 32'h0, 32'h0, "rd_off2"};

    repeat (3) @(negedge CLK);
    chk("rst_out", {DUMP_VALID, DUMP_LAST, BUSY, DUMP_DONE}, 0);
    chk("rst_addr", DUMP_ADDR, 0);
    chk("rst_data", DUMP_DATA, 0);
    RST_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      RD = vt[i].rd; WR = vt[i].wr;
      ADDRESS = vt[i].addr; DATAIN = vt[i].din;
      #1;
      chk(vt[i].name, DATAOUT, vt[i].exp);
      if (vt[i].wr) ref_mem[vt[i].addr[11:2]] = vt[i].din;
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      RD = 1'($urandom);
      WR = ($urandom_range(0, 3) == 0);
      ADDRESS = 12'($urandom_range(0, 63));
      DATAIN = $urandom;
      #1;
      chk("rand_rd", DATAOUT, RD ? ref_mem[ADDRESS[11:2]] : 32'h0);
      if (WR) ref_mem[ADDRESS[11:2]] = DATAIN;
    end
    @(negedge CLK);
    WR = 0; RD = 0;

    run_dump(-1, 0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      WR = 1; ADDRESS = 12'(i * 4); DATAIN = 32'(i);
      ref_mem[i] = DATAIN;
    end
    @(negedge CLK);
    WR = 0;

    run_dump(3, 5, 1'b0, 1'b1, 1'b0);
    run_dump(-1, 0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a dump, then restart from a clean image.
    @(negedge CLK);
    DUMP = 1; DUMP_READY = 1;
    @(negedge CLK);
    DUMP = 0;
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (DUMP_VALID && DUMP_ADDR == 12'd400) hit = 1;
      else @(negedge CLK);
    end
    chk("reach_w100", hit, 1);
    RST_n = 0;
    RD = 1; ADDRESS = 12'h004;
    #1;
    chk("midrst_out", {DUMP_VALID, DUMP_LAST, BUSY, DUMP_DONE}, 0);
    chk("midrst_addr", DUMP_ADDR, 0);
    chk("midrst_data", DUMP_DATA, 0);
    chk("midrst_mem", DATAOUT, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(negedge CLK);
    RST_n = 1; RD = 0; DUMP_READY = 0;
    repeat (5) begin
      @(negedge CLK);
      chk("midrst_nodone", {DUMP_DONE, BUSY}, 0);
    end

    run_dump(-1, 0, 1'b0, 1'b0, 1'b0);

    @(negedge CLK);
    WR = 1; ADDRESS = 12'h014; DATAIN = 32'd7;
    ref_mem[5] = 32'd7;
    @(negedge CLK);
    WR = 0;
    run_dump(-1, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
